// File: rtl/miner_job_loader.sv
// miner_job_loader: assembles a mining job (HDR_WORDS header words followed by
// TGT_WORDS target words, MSB-first) from a 32-bit valid/ready stream into a
// staging register, then commits it to the header/target shadow outputs.
//   Ports: clk/rst; in_data/in_sof/in_valid/in_ready stream input;
//          header/target committed job; job_valid/job_id commit pulse and count;
//          err_frame/err_timeout single-cycle error pulses.
module miner_job_loader #(
  parameter int HDR_WORDS      = 19,
  parameter int TGT_WORDS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             in_data,
  input  logic                    in_sof,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [32*HDR_WORDS-1:0] header,
  output logic [32*TGT_WORDS-1:0] target,
  output logic                    job_valid,
  output logic [7:0]              job_id,
  output logic                    err_frame,
  output logic                    err_timeout
);

  localparam int TOT_WORDS = HDR_WORDS + TGT_WORDS;
  localparam int STG_W     = 32 * TOT_WORDS;
  localparam int CNT_W     = $clog2(TOT_WORDS + 1);
  localparam int LSB_W     = $clog2(STG_W);
  localparam bit TO_EN     = (TIMEOUT_CYCLES > 0);
  localparam int IDLE_W    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int IDLE_MAX  = TO_EN ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  word_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [STG_W-1:0]  staging;

  logic              accept;
  logic              last_word;
  logic              timeout_hit;
  logic [LSB_W-1:0]  word_lsb;

  // Header and target share one staging vector, so word k always lands at
  // the same MSB-first offset regardless of which output it ends up in.
  always_comb begin
    in_ready    = (state != S_COMMIT);
    accept      = in_valid && in_ready;
    last_word   = (word_cnt == CNT_W'(TOT_WORDS - 1));
    word_lsb    = LSB_W'(STG_W - 32 - 32 * int'(word_cnt));
    // Threshold is checked against the count before this edge's increment,
    // so the abort lands on the TIMEOUT_CYCLES-th idle edge. An accepted
    // word on that same edge suppresses the abort.
    timeout_hit = TO_EN && !accept && (idle_cnt == IDLE_W'(IDLE_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && in_sof) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          // A new sof restarts the frame even if it arrives in the last slot.
          if (!in_sof && last_word) state_nxt = S_COMMIT;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt    <= '0;
      idle_cnt    <= '0;
      staging     <= '0;
      header      <= '0;
      target      <= '0;
      job_valid   <= 1'b0;
      job_id      <= '0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      job_valid   <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          idle_cnt <= '0;
          if (accept) begin
            if (in_sof) begin
              staging  <= {in_data, {(STG_W-32){1'b0}}};
              word_cnt <= CNT_W'(1);
            end else begin
              err_frame <= 1'b1;  // orphan word, dropped
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            idle_cnt <= '0;
            if (in_sof) begin
              staging   <= {in_data, {(STG_W-32){1'b0}}};
              word_cnt  <= CNT_W'(1);
              err_frame <= 1'b1;
            end else begin
              staging[word_lsb +: 32] <= in_data;
              word_cnt <= last_word ? '0 : word_cnt + 1'b1;
            end
          end else if (timeout_hit) begin
            staging     <= '0;
            word_cnt    <= '0;
            idle_cnt    <= '0;
            err_timeout <= 1'b1;
          end else if (TO_EN) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_COMMIT: begin
          header    <= staging[STG_W-1 -: 32*HDR_WORDS];
          target    <= staging[32*TGT_WORDS-1:0];
          job_valid <= 1'b1;
          job_id    <= job_id + 1'b1;
          word_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miner_job_loader.sv
// Bench for miner_job_loader: frame-level reference model (word queue plus
// committed job), directed scenarios followed by randomized traffic.
module tb_miner_job_loader;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_sof;
  logic         in_valid;
  logic         in_ready;
  logic [607:0] header;
  logic [255:0] target;
  logic         job_valid;
  logic [7:0]   job_id;
  logic         err_frame;
  logic         err_timeout;

  miner_job_loader #(.HDR_WORDS(19), .TGT_WORDS(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
    .header(header), .target(target),
    .job_valid(job_valid), .job_id(job_id),
    .err_frame(err_frame), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [863:0] got, input logic [863:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: words of the frame in progress, committed job, pulses.
  logic [31:0]  q[$];
  int           idle;
  bit           cpend;
  logic [607:0] m_hdr;
  logic [255:0] m_tgt;
  logic [7:0]   m_id;
  bit           e_jv, e_ef, e_et;

  task automatic model_reset();
    q.delete();
    idle  = 0;
    cpend = 0;
    m_hdr = '0;
    m_tgt = '0;
    m_id  = '0;
    e_jv  = 0; e_ef = 0; e_et = 0;
  endtask

  task automatic model_edge(input bit v, input bit s, input logic [31:0] d);
    e_jv = 0; e_ef = 0; e_et = 0;
    if (cpend) begin
      for (int k = 0; k < 19; k++) m_hdr[607-32*k -: 32] = q[k];
      for (int j = 0; j < 8; j++)  m_tgt[255-32*j -: 32] = q[19+j];
      m_id  = m_id + 8'd1;
      e_jv  = 1;
      cpend = 0;
      q.delete();
    end else if (v) begin
      idle = 0;
      if (s) begin
        if (q.size() > 0) e_ef = 1;
        q.delete();
        q.push_back(d);
      end else if (q.size() == 0) begin
        e_ef = 1;
      end else begin
        q.push_back(d);
        if (q.size() == 27) cpend = 1;
      end
    end else if (q.size() > 0) begin
      idle++;
      if (idle == TO) begin
        q.delete();
        idle = 0;
        e_et = 1;
      end
    end
  endtask

  task automatic check_outs();
    chk("hdr", header, m_hdr);
    chk("tgt", target, m_tgt);
    chk("job_valid", job_valid, e_jv);
    chk("job_id", job_id, m_id);
    chk("err_frame", err_frame, e_ef);
    chk("err_timeout", err_timeout, e_et);
  endtask

  // One clock: inputs driven just after a falling edge, outputs checked on the next.
  task automatic cycle(input bit v, input bit s, input logic [31:0] d, output bit took);
    in_valid = v; in_sof = s; in_data = d;
    #1;
    chk("in_ready", in_ready, !cpend);
    took = v && !cpend;
    @(posedge clk);
    model_edge(v, s, d);
    @(negedge clk);
    check_outs();
  endtask

  // The model never stalls for more than one cycle, so this loop is bounded.
  task automatic send(input bit s, input logic [31:0] d);
    bit took;
    int tries;
    tries = 0;
    do begin
      cycle(1'b1, s, d, took);
      tries++;
    end while (!took && tries < 4);
  endtask

  task automatic idle_n(input int n);
    bit took;
    repeat (n) cycle(1'b0, 1'b0, 32'h0, took);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    model_reset();
    #12;
    chk("rst_hdr", header, '0);
    chk("rst_tgt", target, '0);
    chk("rst_id", job_id, '0);
    chk("rst_jv", job_valid, '0);
    chk("rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Basic load
    send(1'b1, 32'hAAAAAAAA);
    for (int i = 1; i < 19; i++) send(1'b0, 32'hAAAAAAAA);
    for (int i = 19; i < 27; i++) send(1'b0, 32'hFFFF0000);
    idle_n(3);
    chk("basic_hdr", header, {19{32'hAAAAAAAA}});
    chk("basic_tgt", target, {8{32'hFFFF0000}});
    chk("basic_id", job_id, 8'd1);

    // Orphan word in IDLE
    send(1'b0, 32'hDEADBEEF);
    idle_n(2);

    // Mid-frame restart
    send(1'b1, 32'h11111111);
    for (int i = 1; i < 10; i++) send(1'b0, $urandom);
    send(1'b1, 32'h12345678);
    for (int i = 1; i < 27; i++) send(1'b0, 32'h00000001);
    idle_n(3);
    chk("restart_w0", header[607:576], 32'h12345678);
    chk("restart_id", job_id, 8'd2);

    // Timeout abort after exactly TO idle cycles
    send(1'b1, 32'hCAFE0000);
    for (int i = 1; i < 5; i++) send(1'b0, $urandom);
    idle_n(TO + 2);
    chk("timeout_id", job_id, 8'd2);

    // Word arriving on the threshold cycle wins
    send(1'b1, 32'hBEEF0001);
    for (int i = 1; i < 5; i++) send(1'b0, $urandom);
    idle_n(TO - 1);
    for (int i = 5; i < 27; i++) send(1'b0, $urandom);
    idle_n(2);
    chk("nowin_id", job_id, 8'd3);

    // 256 back-to-back frames with valid held high: wraps job_id
    for (int f = 0; f < 256; f++)
      for (int w = 0; w < 27; w++) send(w == 0, $urandom);
    idle_n(2);
    chk("wrap_id", job_id, 8'd3);

    // Random traffic with gaps and stray sof
    for (int c = 0; c < 600; c++) begin
      bit took;
      bit v;
      bit s;
      v = ($urandom_range(0, 9) < 7);
      s = (q.size() == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 39) == 0);
      cycle(v, s, $urandom, took);
    end
    idle_n(TO + 2);

    // Asynchronous reset in the middle of a frame
    send(1'b1, 32'h55555555);
    for (int i = 1; i < 12; i++) send(1'b0, $urandom);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_hdr", header, '0);
    chk("arst_tgt", target, '0);
    chk("arst_id", job_id, '0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_errs", {job_valid, err_frame, err_timeout}, 3'b000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 27; w++) send(w == 0, 32'h0F0F0000 + w);
    idle_n(3);
    chk("arst_next_id", job_id, 8'd1);
    chk("arst_next_w26", target[31:0], 32'h0F0F001A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
